shift_sequencer: RTL and testbench

- Iterative barrel-shift controller for the RISC-V ALU path.
- Accepts an operand, a shift amount and an op on a start pulse, then drives a 1-bit-per-cycle shift stage for exactly shamt cycles.
- Returns the result with a one-cycle done pulse.
- Replaces a combinational barrel shifter with a small serial datapath plus FSM; sits between ALU decode and the writeback mux.

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_step.sv | 51 +++++
 rtl/shift_sequencer.sv | 111 +++++++++++
 tb/tb_shift_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift sequencer: op and FSM state encodings.
// Optional feature macro used by the design: SHIFT_BY_4_EN.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single shift step: one position, or four when SHIFT_BY_4_EN is
// defined and i_by4 is asserted. Fill rules follow the op.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_data,
    input  sh_op_e       i_op,
`ifdef SHIFT_BY_4_EN
    input  logic         i_by4,
`endif
    output logic [N-1:0] o_next
);

    logic [N-1:0] w_step1;
`ifdef SHIFT_BY_4_EN
    logic [N-1:0] w_step4;
`endif

    // One-position step for each op
    always_comb begin
        w_step1 = i_data;
        case (i_op)
            SH_SLL:  w_step1 = {i_data[N-2:0], 1'b0};
            SH_SRL:  w_step1 = {1'b0, i_data[N-1:1]};
            SH_SRA:  w_step1 = {i_data[N-1], i_data[N-1:1]};
            SH_ROR:  w_step1 = {i_data[0], i_data[N-1:1]};
            default: w_step1 = i_data;
        endcase
    end

`ifdef SHIFT_BY_4_EN
    // Four-position step with the same fill rules
    always_comb begin
        w_step4 = i_data;
        case (i_op)
            SH_SLL:  w_step4 = {i_data[N-5:0], 4'b0000};
            SH_SRL:  w_step4 = {4'b0000, i_data[N-1:4]};
            SH_SRA:  w_step4 = {{4{i_data[N-1]}}, i_data[N-1:4]};
            SH_ROR:  w_step4 = {i_data[3:0], i_data[N-1:4]};
            default: w_step4 = i_data;
        endcase
    end

    assign o_next = i_by4 ? w_step4 : w_step1;
`else
    assign o_next = w_step1;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift controller: latches operand/op/shamt on start, steps the
// shift register once per cycle until the count is exhausted, then presents
// the result with a one-cycle done pulse.
// Optional macro SHIFT_BY_4_EN: steps by four while count >= 4.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned SHW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   operand,
    input  logic [SHW-1:0] shamt,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result
);

    sh_state_e      r_state;
    sh_op_e         r_op;
    logic [SHW-1:0] r_count;
    logic [N-1:0]   r_shreg;
    logic [N-1:0]   r_result;
    logic           r_busy;
    logic           r_done;

    logic [N-1:0]   w_next;
    logic [SHW-1:0] w_dec;
    logic           w_last;

`ifdef SHIFT_BY_4_EN
    logic           w_by4;

    assign w_by4 = (r_count >= SHW'(4));
    assign w_dec = w_by4 ? SHW'(4) : SHW'(1);
`else
    assign w_dec = SHW'(1);
`endif

    // Final step of the operation is the one that consumes the remaining count
    assign w_last = (r_count == w_dec);

    shift_step #(
        .N (N)
    ) u_step (
        .i_data (r_shreg),
        .i_op   (r_op),
`ifdef SHIFT_BY_4_EN
        .i_by4  (w_by4),
`endif
        .o_next (w_next)
    );

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_op     <= SH_SLL;
            r_count  <= '0;
            r_shreg  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shreg <= operand;
                        r_op    <= sh_op_e'(op);
                        r_count <= shamt;
                        r_busy  <= 1'b1;
                        if (shamt == '0) begin
                            r_state  <= ST_DONE;
                            r_result <= operand;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= w_next;
                    r_count <= r_count - w_dec;
                    if (w_last) begin
                        r_state  <= ST_DONE;
                        r_result <= w_next;
                        r_done   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer (default build, or SHIFT_BY_4_EN).
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(
        .N   (32),
        .SHW (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [4:0] sh);
`ifdef SHIFT_BY_4_EN
        return int'(sh) / 4 + int'(sh) % 4 + 1;
`else
        return int'(sh) + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start (sampled at the next edge) and follow the op to completion.
    task automatic run_op(input string nm, input logic [1:0] op_v, input logic [31:0] opd,
                          input logic [4:0] sh, input logic [31:0] exp_res);
        int cyc;
        logic busy_ok;
        logic [31:0] res_hold;
        op = op_v; operand = opd; shamt = sh; start = 1'b1;
        tick();
        start = 1'b0;
        // scramble don't-care inputs mid-operation
        op = ~op_v; operand = ~opd; shamt = ~sh;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat(sh)));
        chk({nm, " busy during op"}, 32'(busy_ok & busy), 32'd1);
        chk({nm, " result"}, result, exp_res);
        res_hold = result;
        tick();
        chk({nm, " done pulse end"}, 32'(done), 32'd0);
        chk({nm, " busy end"}, 32'(busy), 32'd0);
        tick();
        chk({nm, " result hold"}, result, res_hold);
    endtask

    vec_t vecs[11];
    int   npulse;

    initial begin
        vecs[0]  = '{"sll1x5",   2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020};
        vecs[1]  = '{"sra31",    2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[2]  = '{"srl31",    2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[3]  = '{"ror1",     2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000};
        vecs[4]  = '{"zero",     2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[5]  = '{"ror8",     2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456};
        vecs[6]  = '{"sra4pos",  2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
        vecs[7]  = '{"srl4",     2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000};
        vecs[8]  = '{"sll9",     2'b00, 32'h0000_0001, 5'd9,  32'h0000_0200};
        vecs[9]  = '{"sra6neg",  2'b10, 32'h8000_0000, 5'd6,  32'hFE00_0000};
        vecs[10] = '{"ror3",     2'b11, 32'h0000_000F, 5'd3,  32'hE000_0001};

        reset = 1'b0; start = 1'b0; op = 2'b00; operand = '0; shamt = '0;
        tick();
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        reset = 1'b1;
        tick();
        chk("idle no start", 32'(busy), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].operand, vecs[i].shamt, vecs[i].exp);
        end

        // Starts while busy, including in the DONE cycle, must be ignored.
        op = 2'b00; operand = 32'h1; shamt = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        npulse = 0;
        for (int c = 0; c < 16; c++) begin
            if (done) npulse++;
            if (c == 2 || done) begin
                start = 1'b1; operand = 32'hFFFF_FFFF; shamt = 5'd0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("busy start pulses", 32'(npulse), 32'd1);
        chk("busy start result", result, 32'h0000_0020);
        chk("busy start idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a long shift.
        op = 2'b00; operand = 32'h1; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        chk("pre-reset busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        chk("async reset result", result, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        npulse = 0;
        for (int c = 0; c < 25; c++) begin
            if (done || busy) npulse++;
            tick();
        end
        chk("no done after reset", 32'(npulse), 32'd0);
        run_op("post-reset", 2'b01, 32'hA5A5_0000, 5'd8, 32'h00A5_A500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
